// File: rtl/key_led_pkg.sv
// key_led_pkg: mode and LED pattern constants plus pattern helpers for key_led_ctrl.
package key_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_RUN   = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    localparam logic [3:0] LED_ALL_OFF  = 4'b0000;
    localparam logic [3:0] LED_ALL_ON   = 4'b1111;
    localparam logic [3:0] LED_RUN_INIT = 4'b0001;

    function automatic logic [3:0] init_pattern(input logic [1:0] mode);
        return mode == MODE_RUN ? LED_RUN_INIT : mode == MODE_OFF ? LED_ALL_OFF : LED_ALL_ON;
    endfunction

    // Constant modes simply re-assert their initial pattern on each step.
    function automatic logic [3:0] step_pattern(input logic [1:0] mode, input logic [3:0] pat);
        return mode == MODE_RUN ? {pat[2:0], pat[3]} : mode == MODE_BLINK ? ~pat : init_pattern(mode);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser, debounce counter and one-cycle press pulse for an active-low key.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_press,
    output logic key_stable
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q;
    logic          key_s, done, stable_q, stable_d, press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        key_s    = sync_q[1];
        done     = key_s != stable_q && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
        cnt_d    = (key_s == stable_q || done) ? '0 : cnt_q + 1'b1;
        stable_d = done ? key_s : stable_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], key};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= stable_q & ~stable_d;
        end
    end

    assign key_press  = press_q;
    assign key_stable = stable_q;

endmodule

// File: rtl/key_led_ctrl.sv
// key_led_ctrl: debounced push-button stepping a 2-bit mode that selects a 4-bit LED animation.
// Define LED_ACTIVE_LOW_EN to drive led inverted for LEDs wired to VCC.
module key_led_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STEP_CYCLES     = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    output logic       key_press,
    output logic [1:0] ctrl,
    output logic [3:0] led
);
    import key_led_pkg::*;

    localparam int TW = $clog2(STEP_CYCLES);

    logic          key_stable, mode_chg, step_tick;
    logic [1:0]    ctrl_q, ctrl_prev_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    pat_q, pat_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .key_press (key_press),
        .key_stable(key_stable)
    );

    // Folding the pulse in makes ctrl advance on the same edge that raises key_press.
    always_comb begin
        ctrl      = ctrl_q + {1'b0, key_press & ~key_stable};
        mode_chg  = ctrl != ctrl_prev_q;
        step_tick = timer_q == TW'(STEP_CYCLES - 1);
        timer_d   = (mode_chg || step_tick) ? '0 : timer_q + 1'b1;
        pat_d     = mode_chg ? init_pattern(ctrl) : step_tick ? step_pattern(ctrl, pat_q) : pat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q      <= MODE_OFF;
            ctrl_prev_q <= MODE_OFF;
            timer_q     <= '0;
            pat_q       <= LED_ALL_OFF;
        end else begin
            ctrl_q      <= ctrl;
            ctrl_prev_q <= ctrl;
            timer_q     <= timer_d;
            pat_q       <= pat_d;
        end
    end

`ifdef LED_ACTIVE_LOW_EN
    assign led = ~pat_q;
`else
    assign led = pat_q;
`endif

endmodule

// File: tb/tb_key_led_ctrl.sv
// tb_key_led_ctrl: directed vector table plus hand-written press/animation/reset sequences.
module tb_key_led_ctrl;

    logic       clk = 1'b0, rst = 1'b1, key = 1'b1;
    logic       key_press;
    logic [1:0] ctrl;
    logic [3:0] led;
    int         n_checks = 0, n_fail = 0, press_cnt = 0;

    typedef struct {
        logic       rst;
        logic       key;
        int         n;
        logic       press;
        logic [1:0] ctrl;
        logic [3:0] pat;
    } vec_t;

    key_led_ctrl #(.DEBOUNCE_CYCLES(8), .STEP_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .key_press(key_press),
        .ctrl     (ctrl),
        .led      (led)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (key_press === 1'b1) press_cnt++;

    function automatic logic [3:0] vis(input logic [3:0] p);
`ifdef LED_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_state(input string tag, input logic p, input logic [1:0] c, input logic [3:0] pat);
        check({tag, "_press"}, key_press, p);
        check({tag, "_ctrl"}, ctrl, c);
        check({tag, "_led"}, led, vis(pat));
    endtask

    // Holds the key down until the pulse appears (bounded), leaving key pressed.
    task automatic press_to(input logic [1:0] c);
        int k = 0;
        key = 1'b0;
        while (key_press !== 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        check("press_seen", key_press, 1'b1);
        check("press_ctrl", ctrl, c);
    endtask

    task automatic release_key();
        key = 1'b1;
        tick(20);
    endtask

    initial begin
        vec_t       tbl[8];
        logic [3:0] run_exp[4];
        int         base;
        // Pulse lands on the 10th edge counting the one that first samples key=0.
        tbl[0] = '{1'b1, 1'b1, 1,  1'b0, 2'd0, 4'b0000};
        tbl[1] = '{1'b1, 1'b1, 1,  1'b0, 2'd0, 4'b0000};
        tbl[2] = '{1'b1, 1'b1, 1,  1'b0, 2'd0, 4'b0000};
        tbl[3] = '{1'b0, 1'b1, 2,  1'b0, 2'd0, 4'b0000};
        tbl[4] = '{1'b0, 1'b0, 9,  1'b0, 2'd0, 4'b0000};
        tbl[5] = '{1'b0, 1'b0, 1,  1'b1, 2'd1, 4'b0000};
        tbl[6] = '{1'b0, 1'b0, 1,  1'b0, 2'd1, 4'b1111};
        tbl[7] = '{1'b0, 1'b0, 9,  1'b0, 2'd1, 4'b1111};
        for (int i = 0; i < 8; i++) begin
            rst = tbl[i].rst;
            key = tbl[i].key;
            tick(tbl[i].n);
            expect_state($sformatf("vec%0d", i), tbl[i].press, tbl[i].ctrl, tbl[i].pat);
        end
        check("hold_one_press", press_cnt, 1);
        key = 1'b1;
        tick(20);
        expect_state("release", 1'b0, 2'd1, 4'b1111);
        check("release_no_press", press_cnt, 1);

        base = press_cnt;
        for (int i = 0; i < 10; i++) begin
            key = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(3);
        end
        key = 1'b1;
        tick(12);
        check("bounce_no_press", press_cnt, base);
        check("bounce_ctrl", ctrl, 2'd1);

        run_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        press_to(2'd2);
        tick(1);
        check("run_init", led, vis(4'b0001));
        for (int i = 0; i < 4; i++) begin
            tick(4);
            check($sformatf("run_step%0d", i), led, vis(run_exp[i]));
        end
        check("run_hold_ctrl", ctrl, 2'd2);
        release_key();

        press_to(2'd3);
        tick(1);
        check("blink_init", led, vis(4'b1111));
        tick(4);
        check("blink_off", led, vis(4'b0000));
        tick(4);
        check("blink_on", led, vis(4'b1111));
        release_key();

        press_to(2'd0);
        tick(1);
        check("wrap_led", led, vis(4'b0000));
        tick(8);
        expect_state("wrap_const", 1'b0, 2'd0, 4'b0000);
        release_key();

        press_to(2'd1);
        release_key();
        base = press_cnt;
        key = 1'b0;
        tick(5);
        rst = 1'b1;
        key = 1'b1;
        tick(1);
        expect_state("rst_mid", 1'b0, 2'd0, 4'b0000);
        rst = 1'b0;
        tick(15);
        expect_state("rst_after", 1'b0, 2'd0, 4'b0000);
        check("rst_no_press", press_cnt, base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
